// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle controller (master) and the datapath/memory (slave).
// The controller drives the strobes, selects, illegal and state; the datapath returns opcode, branch_cond and mem_ready.
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic       branch_cond;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       adr_src;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, branch_cond, mem_ready,
    output pc_write, ir_write, adr_src, mem_write, reg_write,
    output result_src, alu_src_a, alu_src_b, alu_op, illegal, state
  );

  modport slave (
    output opcode, branch_cond, mem_ready,
    input  pc_write, ir_write, adr_src, mem_write, reg_write,
    input  result_src, alu_src_a, alu_src_b, alu_op, illegal, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore FSM sequencing a multicycle RV32I-style datapath; all outputs decode from the current state.
// Memory waits stall in FETCH/MEMREAD/MEMWRITE until mem_ready; an unsupported opcode parks in TRAP until reset.
module multicycle_ctrl (
  input  logic             clk,
  input  logic             reset,
  multicycle_ctrl_if.master bus
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR     = 4'd11;
  localparam logic [3:0] S_LUI      = 4'd12;
  localparam logic [3:0] S_AUIPC    = 4'd13;
  localparam logic [3:0] S_TRAP     = 4'd14;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_RS1   = 2'b10;
  localparam logic [1:0] A_ZERO  = 2'b11;

  localparam logic [1:0] B_RS2   = 2'b00;
  localparam logic [1:0] B_IMM   = 2'b01;
  localparam logic [1:0] B_FOUR  = 2'b10;

  localparam logic [1:0] OPC_ADD   = 2'b00;
  localparam logic [1:0] OPC_CMP   = 2'b01;
  localparam logic [1:0] OPC_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  logic [3:0] state_q, state_d;
  logic       illegal_q, illegal_d;

  logic       pc_write_raw;
  logic       ir_write_raw;
  logic       mem_write_raw;
  logic       reg_write_raw;

  // Next-state logic; opcode and branch_cond are only looked at in the states that consume them.
  always_comb begin
    state_d   = S_FETCH;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LOAD,
          OP_STORE:  state_d = S_MEMADR;
          OP_RTYPE:  state_d = S_EXECR;
          OP_ITYPE:  state_d = S_EXECI;
          OP_BRANCH: state_d = S_BRANCH;
          OP_JAL:    state_d = S_JAL;
          OP_JALR:   state_d = S_JALR;
          OP_LUI:    state_d = S_LUI;
          OP_AUIPC:  state_d = S_AUIPC;
          default:   state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_JAL;
      S_LUI:      state_d = S_ALUWB;
      S_AUIPC:    state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
    if (state_d == S_TRAP) begin
      illegal_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore output decode; unlisted outputs stay at their zero default.
  always_comb begin
    pc_write_raw   = 1'b0;
    ir_write_raw   = 1'b0;
    mem_write_raw  = 1'b0;
    reg_write_raw  = 1'b0;
    bus.adr_src    = 1'b0;
    bus.result_src = RES_ALUOUT;
    bus.alu_src_a  = A_PC;
    bus.alu_src_b  = B_RS2;
    bus.alu_op     = OPC_ADD;
    case (state_q)
      S_FETCH: begin
        bus.alu_src_b  = B_FOUR;
        bus.result_src = RES_ALU;
        ir_write_raw   = bus.mem_ready;
        pc_write_raw   = bus.mem_ready;
      end
      S_DECODE: begin
        bus.alu_src_a = A_OLDPC;
        bus.alu_src_b = B_IMM;
      end
      S_MEMADR: begin
        bus.alu_src_a = A_RS1;
        bus.alu_src_b = B_IMM;
      end
      S_MEMREAD: bus.adr_src = 1'b1;
      S_MEMWB: begin
        bus.result_src = RES_MEM;
        reg_write_raw  = 1'b1;
      end
      S_MEMWRITE: begin
        bus.adr_src   = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECR: begin
        bus.alu_src_a = A_RS1;
        bus.alu_src_b = B_RS2;
        bus.alu_op    = OPC_FUNCT;
      end
      S_EXECI: begin
        bus.alu_src_a = A_RS1;
        bus.alu_src_b = B_IMM;
        bus.alu_op    = OPC_FUNCT;
      end
      S_ALUWB: reg_write_raw = 1'b1;
      S_BRANCH: begin
        bus.alu_src_a = A_RS1;
        bus.alu_src_b = B_RS2;
        bus.alu_op    = OPC_CMP;
        pc_write_raw  = bus.branch_cond;
      end
      S_JAL: begin
        // PC takes the target already in ALUOut while OldPC+4 is computed as the link value.
        bus.alu_src_a = A_OLDPC;
        bus.alu_src_b = B_FOUR;
        pc_write_raw  = 1'b1;
      end
      S_JALR: begin
        bus.alu_src_a = A_RS1;
        bus.alu_src_b = B_IMM;
      end
      S_LUI: begin
        bus.alu_src_a = A_ZERO;
        bus.alu_src_b = B_IMM;
      end
      S_AUIPC: begin
        bus.alu_src_a = A_OLDPC;
        bus.alu_src_b = B_IMM;
      end
      default: ;
    endcase
  end

  // Strobes are gated by reset directly so nothing commits while reset is held, even in FETCH.
  assign bus.pc_write  = pc_write_raw  & ~reset;
  assign bus.ir_write  = ir_write_raw  & ~reset;
  assign bus.mem_write = mem_write_raw & ~reset;
  assign bus.reg_write = reg_write_raw & ~reset;
  assign bus.illegal   = illegal_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: expected output vectors are queued as each step is driven and popped when sampled.
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  multicycle_ctrl_if bus();
  multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       irw;
    logic       adr;
    logic       mw;
    logic       rw;
    logic [1:0] rs;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] op;
    logic       ill;
  } obs_t;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  // Expected outputs per state, written straight from the state table.
  function automatic obs_t model(input logic [3:0] st, input logic mr, input logic bc);
    obs_t e;
    e = '0;
    e.st = st;
    case (st)
      4'd0:  begin e.adr = 0; e.a = 2'b00; e.b = 2'b10; e.op = 2'b00; e.rs = 2'b10; e.irw = mr; e.pcw = mr; end
      4'd1:  begin e.a = 2'b01; e.b = 2'b01; end
      4'd2:  begin e.a = 2'b10; e.b = 2'b01; end
      4'd3:  e.adr = 1;
      4'd4:  begin e.rs = 2'b01; e.rw = 1; end
      4'd5:  begin e.adr = 1; e.mw = 1; end
      4'd6:  begin e.a = 2'b10; e.b = 2'b00; e.op = 2'b10; end
      4'd7:  begin e.a = 2'b10; e.b = 2'b01; e.op = 2'b10; end
      4'd8:  e.rw = 1;
      4'd9:  begin e.a = 2'b10; e.op = 2'b01; e.pcw = bc; end
      4'd10: begin e.pcw = 1; e.a = 2'b01; e.b = 2'b10; end
      4'd11: begin e.a = 2'b10; e.b = 2'b01; end
      4'd12: begin e.a = 2'b11; e.b = 2'b01; end
      4'd13: begin e.a = 2'b01; e.b = 2'b01; end
      4'd14: e.ill = 1;
      default: ;
    endcase
    return e;
  endfunction

  function automatic obs_t observe();
    obs_t g;
    g.st  = bus.state;
    g.pcw = bus.pc_write;
    g.irw = bus.ir_write;
    g.adr = bus.adr_src;
    g.mw  = bus.mem_write;
    g.rw  = bus.reg_write;
    g.rs  = bus.result_src;
    g.a   = bus.alu_src_a;
    g.b   = bus.alu_src_b;
    g.op  = bus.alu_op;
    g.ill = bus.illegal;
    return g;
  endfunction

  task automatic check(input string tag);
    obs_t e, g;
    e = exp_q.pop_front();
    g = observe();
    checks++;
    assert (g === e) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, g, e);
    end
  endtask

  // Drive one cycle's inputs, check the current state's outputs, then advance one clock.
  task automatic step(input logic mr, input logic bc, input logic [3:0] st, input string tag);
    bus.mem_ready   = mr;
    bus.branch_cond = bc;
    exp_q.push_back(model(st, mr, bc));
    #1;
    check(tag);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset must take effect without a clock edge; mem_ready=1 shows strobes stay low under reset.
  task automatic pulse_reset(input string tag);
    bus.mem_ready = 1'b1;
    reset = 1'b1;
    exp_q.push_back(model(4'd0, 1'b0, 1'b0));
    #1;
    check(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset           = 1'b0;
    bus.opcode      = OP_RTYPE;
    bus.branch_cond = 1'b0;
    bus.mem_ready   = 1'b1;
    #1;
    pulse_reset("reset_init");

    // R-type: 0,1,6,8 then FETCH
    bus.opcode = OP_RTYPE;
    step(1, 0, 4'd0, "r_fetch");
    step(1, 0, 4'd1, "r_decode");
    step(1, 0, 4'd6, "r_execr");
    step(1, 0, 4'd8, "r_aluwb");

    // Load with a FETCH wait and two MEMREAD waits
    bus.opcode = OP_LOAD;
    step(0, 0, 4'd0, "ld_fetch_wait");
    step(1, 0, 4'd0, "ld_fetch");
    step(1, 0, 4'd1, "ld_decode");
    step(1, 0, 4'd2, "ld_memadr");
    step(0, 0, 4'd3, "ld_memread_w1");
    step(0, 0, 4'd3, "ld_memread_w2");
    step(1, 0, 4'd3, "ld_memread");
    step(1, 0, 4'd4, "ld_memwb");

    // Store with one MEMWRITE wait
    bus.opcode = OP_STORE;
    step(1, 0, 4'd0, "st_fetch");
    step(1, 0, 4'd1, "st_decode");
    step(1, 0, 4'd2, "st_memadr");
    step(0, 0, 4'd5, "st_memwrite_w");
    step(1, 0, 4'd5, "st_memwrite");

    // Branch not taken, then taken
    bus.opcode = OP_BRANCH;
    step(1, 0, 4'd0, "bnt_fetch");
    step(1, 0, 4'd1, "bnt_decode");
    step(1, 0, 4'd9, "bnt_branch");
    step(1, 1, 4'd0, "bt_fetch");
    step(1, 1, 4'd1, "bt_decode");
    step(1, 1, 4'd9, "bt_branch");

    // JALR: 0,1,11,10,8,0
    bus.opcode = OP_JALR;
    step(1, 0, 4'd0, "jalr_fetch");
    step(1, 0, 4'd1, "jalr_decode");
    step(1, 0, 4'd11, "jalr_jalr");
    step(1, 0, 4'd10, "jalr_jal");
    step(1, 0, 4'd8, "jalr_aluwb");

    bus.opcode = OP_JAL;
    step(1, 0, 4'd0, "jal_fetch");
    step(1, 0, 4'd1, "jal_decode");
    step(1, 0, 4'd10, "jal_jal");
    step(1, 0, 4'd8, "jal_aluwb");

    bus.opcode = OP_ITYPE;
    step(1, 0, 4'd0, "i_fetch");
    step(1, 0, 4'd1, "i_decode");
    step(1, 0, 4'd7, "i_execi");
    step(1, 0, 4'd8, "i_aluwb");

    bus.opcode = OP_LUI;
    step(1, 0, 4'd0, "lui_fetch");
    step(1, 0, 4'd1, "lui_decode");
    step(1, 0, 4'd12, "lui_lui");
    step(1, 0, 4'd8, "lui_aluwb");

    bus.opcode = OP_AUIPC;
    step(1, 0, 4'd0, "auipc_fetch");
    step(1, 0, 4'd1, "auipc_decode");
    step(1, 0, 4'd13, "auipc_auipc");
    step(1, 0, 4'd8, "auipc_aluwb");

    // Reset during a MEMREAD wait abandons the load; the next instruction starts cleanly
    bus.opcode = OP_LOAD;
    step(1, 0, 4'd0, "abort_fetch");
    step(1, 0, 4'd1, "abort_decode");
    step(1, 0, 4'd2, "abort_memadr");
    step(0, 0, 4'd3, "abort_memread_w");
    pulse_reset("reset_in_memwait");
    bus.opcode = OP_RTYPE;
    step(1, 0, 4'd0, "post_rst_fetch");
    step(1, 0, 4'd1, "post_rst_decode");
    step(1, 0, 4'd6, "post_rst_execr");
    step(1, 0, 4'd8, "post_rst_aluwb");

    // Illegal opcode parks in TRAP regardless of inputs
    bus.opcode = OP_BAD;
    step(1, 0, 4'd0, "trap_fetch");
    step(1, 0, 4'd1, "trap_decode");
    for (int i = 0; i < 20; i++) begin
      bus.opcode = (i % 2 == 0) ? OP_RTYPE : OP_BAD;
      step(i[0], i[1], 4'd14, "trap_hold");
    end
    pulse_reset("reset_from_trap");
    bus.opcode = OP_ITYPE;
    step(1, 0, 4'd0, "post_trap_fetch");
    step(1, 0, 4'd1, "post_trap_decode");
    step(1, 0, 4'd7, "post_trap_execi");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  7  instruction[6:0] from the IR register; stable after DECODE.
- branch_cond  in  1  branch-taken flag from the datapath comparator.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  PC register write enable.
- ir_write  out  1  IR and OldPC register write enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  out  1  memory write strobe.
- reg_write  out  1  register file write enable.
- result_src  out  2  result select: 00 = ALUOut, 01 = memory data, 10 = ALU result.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4.
- alu_op  out  2  ALU op class: 00 = add, 01 = compare, 10 = funct-decoded.
- illegal  out  1  sticky flag: an unsupported opcode was decoded.
- state  out  4  current state encoding, for debug.

Function
REQ-002 The block SHALL be a Moore FSM with these encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, LUI=12, AUIPC=13, TRAP=14.
REQ-003 Any output not listed for a state SHALL be 0 in that state.
REQ-004 FETCH: adr_src=0, a=00, b=10, alu_op=00, result_src=10.
- ir_write=pc_write=mem_ready.
- Stay in FETCH while mem_ready=0; otherwise go to DECODE.
REQ-005 DECODE: a=01, b=01, alu_op=00 (branch/JAL target into ALUOut). Next state by opcode:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1100011 -> BRANCH
- 1101111 -> JAL
- 1100111 -> JALR
- 0110111 -> LUI
- 0010111 -> AUIPC
- any other opcode -> TRAP
REQ-006 MEMADR: a=10, b=01, alu_op=00. Go to MEMREAD if opcode[5]=0, else MEMWRITE.
REQ-007 MEMREAD: adr_src=1. Hold the state until mem_ready=1, then go to MEMWB.
REQ-008 MEMWB: result_src=01, reg_write=1; then go to FETCH.
REQ-009 MEMWRITE: adr_src=1, mem_write=1 held continuously until the cycle mem_ready=1, then go to FETCH.
REQ-010 EXECR: a=10, b=00, alu_op=10. EXECI: a=10, b=01, alu_op=10. Both go to ALUWB.
REQ-011 ALUWB: result_src=00, reg_write=1; then go to FETCH.
REQ-012 BRANCH: a=10, b=00, alu_op=01, result_src=00, pc_write=branch_cond; then go to FETCH.
REQ-013 JAL: result_src=00, pc_write=1 (PC <= ALUOut target), with a=01, b=10, alu_op=00 (OldPC+4 into ALUOut); then go to ALUWB.
REQ-014 JALR: a=10, b=01, alu_op=00 (rs1+imm into ALUOut); then go to JAL.
REQ-015 LUI: a=11, b=01, alu_op=00. AUIPC: a=01, b=01, alu_op=00. Both go to ALUWB.
REQ-016 TRAP: illegal=1 and all strobes 0. The FSM SHALL stay in TRAP until reset.
REQ-017 Instruction latency in cycles, excluding wait states:
- load 5, store 4
- R/I-type 4, LUI/AUIPC 4
- branch 3
- JAL 4, JALR 5
REQ-018 Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE SHALL add exactly one cycle, with all outputs held unchanged.
REQ-019 opcode and branch_cond SHALL be sampled only in the states that use them.

Reset
REQ-020 reset=1 SHALL force state to FETCH and clear illegal asynchronously, with no clock edge needed.
REQ-021 While reset=1, pc_write, ir_write, mem_write and reg_write SHALL be 0.
REQ-022 Reset asserted mid-instruction, including during a memory wait, SHALL abandon that instruction. The first rising edge after deassertion SHALL evaluate FETCH.
REQ-023 Unknown encodings 15 or above SHALL transition to FETCH on the next edge.

Verification
REQ-024 Reset pulse, then opcode=0110011 and mem_ready=1 -> states 0,1,6,8,0; reg_write=1 only in state 8.
REQ-025 Load (0000011) with mem_ready=0 for 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0; adr_src=1 in all three MEMREAD cycles.
REQ-026 Store (0100011) -> mem_write=1 for exactly the MEMWRITE cycles; never in FETCH.
REQ-027 Branch with branch_cond=0, then branch_cond=1 -> pc_write=0, then 1, in state 9.
REQ-028 JALR -> states 0,1,11,10,8,0; pc_write=1 in state 10 and in state 0.
REQ-029 opcode=1111111 -> illegal=1, state stays 14 for 20 cycles; asserting reset -> state=0 and illegal=0 immediately.
